// File: rtl/pipe_fetch_ctrl.sv
// pipe_fetch_ctrl
// Fetch sequencer that owns the architectural PC feeding pipe_stage_if.
// It loads the IF-stage next-PC mux output and honours load-use stalls from
// the ID hazard unit. It also provides debug halt/single-step and inserts one
// warm-up (BOOT) cycle after reset to cover the synchronous instruction ROM.
// It keeps fetch, redirect and stall statistics.
//
// Ports:
//   clock        in   pipeline clock, rising edge
//   resetn       in   asynchronous active-low reset
//   new_pc       in   next PC from the IF mux
//   pcsource     in   IF mux select (statistics only; nonzero = redirect)
//   wpcir        in   PC write enable from the ID hazard unit (0 = stall)
//   halt         in   debug halt request, level-sensitive
//   step         in   debug single-step, rising-edge triggered
//   pc           out  current fetch PC
//   pc_write     out  PC register loads new_pc this cycle (combinational)
//   if_valid     out  IF/ID should accept the fetched instruction (combinational)
//   state        out  FSM state: BOOT=00, RUN=01, HALT=10, STEP=11
//   fetch_cnt    out  PC advances, wrapping
//   redirect_cnt out  advances with pcsource != 0, wrapping
//   stall_cnt    out  RUN/STEP cycles with wpcir=0, saturating
//
// state | meaning
// ------+-------------------------------------------------------------
// BOOT  | one warm-up cycle after reset while the ROM output settles
// RUN   | free-running fetch; halt has priority over an advance
// HALT  | debug halt; pc and counters hold
// STEP  | one debug advance pending; halt ignored until it happens

module pipe_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          STALL_CW = 16
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [31:0]         new_pc,
  input  logic [1:0]          pcsource,
  input  logic                wpcir,
  input  logic                halt,
  input  logic                step,
  output logic [31:0]         pc,
  output logic                pc_write,
  output logic                if_valid,
  output logic [1:0]          state,
  output logic [31:0]         fetch_cnt,
  output logic [31:0]         redirect_cnt,
  output logic [STALL_CW-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10,
    ST_STEP = 2'b11
  } state_t;

  state_t state_q;
  logic   step_d;
  logic   stall_now;

  assign state = state_q;

  always_comb begin
    pc_write  = 1'b0;
    if_valid  = 1'b0;
    stall_now = 1'b0;
    case (state_q)
      ST_RUN: begin
        if_valid  = 1'b1;
        // halt wins over an advance in the same cycle
        pc_write  = !halt && wpcir;
        stall_now = !halt && !wpcir;
      end
      ST_STEP: begin
        if_valid  = 1'b1;
        pc_write  = wpcir;
        stall_now = !wpcir;
      end
      default: begin
        pc_write  = 1'b0;
        if_valid  = 1'b0;
        stall_now = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_BOOT;
      pc           <= RESET_PC;
      fetch_cnt    <= 32'd0;
      redirect_cnt <= 32'd0;
      stall_cnt    <= '0;
      step_d       <= 1'b0;
    end else begin
      step_d <= step;

      if (pc_write) begin
        pc        <= new_pc;
        fetch_cnt <= fetch_cnt + 32'd1;
        if (pcsource != 2'b00)
          redirect_cnt <= redirect_cnt + 32'd1;
      end

      if (stall_now && (stall_cnt != '1))
        stall_cnt <= stall_cnt + STALL_CW'(1);

      case (state_q)
        ST_BOOT: state_q <= halt ? ST_HALT : ST_RUN;
        ST_RUN: begin
          if (halt)
            state_q <= ST_HALT;
        end
        ST_HALT: begin
          // release beats step; step only counts on its rising edge
          if (!halt)
            state_q <= ST_RUN;
          else if (step && !step_d)
            state_q <= ST_STEP;
        end
        ST_STEP: begin
          if (wpcir)
            state_q <= ST_HALT;
        end
        default: state_q <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
// tb_pipe_fetch_ctrl
// Directed-vector bench for pipe_fetch_ctrl. A driver applies one vector per
// cycle on the falling edge and queues the hand-computed outputs expected in
// that cycle; a separate monitor pops and compares them shortly after.

module tb_pipe_fetch_ctrl;

  logic        clock;
  logic        resetn;
  logic [31:0] new_pc;
  logic [1:0]  pcsource;
  logic        wpcir;
  logic        halt;
  logic        step;
  logic [31:0] pc;
  logic        pc_write;
  logic        if_valid;
  logic [1:0]  state;
  logic [31:0] fetch_cnt;
  logic [31:0] redirect_cnt;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        pw;
    logic        iv;
    logic [1:0]  st;
    logic [31:0] fc;
    logic [31:0] rc;
    logic [15:0] sc;
  } exp_t;

  exp_t exp_q[$];

  pipe_fetch_ctrl #(.RESET_PC(32'h0000_0000), .STALL_CW(16)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .new_pc       (new_pc),
    .pcsource     (pcsource),
    .wpcir        (wpcir),
    .halt         (halt),
    .step         (step),
    .pc           (pc),
    .pc_write     (pc_write),
    .if_valid     (if_valid),
    .state        (state),
    .fetch_cnt    (fetch_cnt),
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic vec(input string nm, input logic rn, input logic [31:0] npc,
                     input logic [1:0] ps, input logic w, input logic h,
                     input logic s, input logic [31:0] epc, input logic epw,
                     input logic eiv, input logic [1:0] est,
                     input logic [31:0] efc, input logic [31:0] erc,
                     input logic [15:0] esc);
    exp_t e;
    @(negedge clock);
    resetn   = rn;
    new_pc   = npc;
    pcsource = ps;
    wpcir    = w;
    halt     = h;
    step     = s;
    e.name = nm; e.pc = epc; e.pw = epw; e.iv = eiv; e.st = est;
    e.fc = efc; e.rc = erc; e.sc = esc;
    exp_q.push_back(e);
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (pc !== e.pc || pc_write !== e.pw || if_valid !== e.iv ||
            state !== e.st || fetch_cnt !== e.fc || redirect_cnt !== e.rc ||
            stall_cnt !== e.sc) begin
          errors++;
          $display("FAIL %s: got pc=%h pw=%b iv=%b st=%b fc=%h rc=%h sc=%h, want pc=%h pw=%b iv=%b st=%b fc=%h rc=%h sc=%h",
                   e.name, pc, pc_write, if_valid, state, fetch_cnt, redirect_cnt, stall_cnt,
                   e.pc, e.pw, e.iv, e.st, e.fc, e.rc, e.sc);
        end
      end
    end
  end

  // driver
  initial begin
    resetn = 1'b0; new_pc = '0; pcsource = '0; wpcir = 1'b0; halt = 1'b0; step = 1'b0;

    //   name            rn npc           ps    w  h  s  pc            pw iv st     fc            rc     sc
    vec("reset",         0, 32'h0,        2'd0, 1, 0, 0, 32'h0,        0, 0, 2'b00, 32'd0,        32'd0, 16'd0);
    vec("boot",          1, 32'h4,        2'd0, 1, 0, 0, 32'h0,        0, 0, 2'b00, 32'd0,        32'd0, 16'd0);
    vec("run_adv0",      1, 32'h4,        2'd0, 1, 0, 0, 32'h0,        1, 1, 2'b01, 32'd0,        32'd0, 16'd0);
    vec("run_adv1",      1, 32'h8,        2'd0, 1, 0, 0, 32'h4,        1, 1, 2'b01, 32'd1,        32'd0, 16'd0);
    vec("run_adv2",      1, 32'hC,        2'd0, 1, 0, 0, 32'h8,        1, 1, 2'b01, 32'd2,        32'd0, 16'd0);
    vec("run_adv3",      1, 32'h10,       2'd0, 1, 0, 0, 32'hC,        1, 1, 2'b01, 32'd3,        32'd0, 16'd0);
    vec("stall1",        1, 32'h14,       2'd0, 0, 0, 0, 32'h10,       0, 1, 2'b01, 32'd4,        32'd0, 16'd0);
    vec("stall2",        1, 32'h14,       2'd0, 0, 0, 0, 32'h10,       0, 1, 2'b01, 32'd4,        32'd0, 16'd1);
    vec("stall3",        1, 32'h14,       2'd0, 0, 0, 0, 32'h10,       0, 1, 2'b01, 32'd4,        32'd0, 16'd2);
    vec("redirect",      1, 32'h40,       2'd1, 1, 0, 0, 32'h10,       1, 1, 2'b01, 32'd4,        32'd0, 16'd3);
    vec("jump",          1, 32'h20,       2'd2, 1, 0, 0, 32'h40,       1, 1, 2'b01, 32'd5,        32'd1, 16'd3);
    vec("halt_prio",     1, 32'h24,       2'd0, 1, 1, 0, 32'h20,       0, 1, 2'b01, 32'd6,        32'd2, 16'd3);
    vec("halted",        1, 32'h24,       2'd0, 1, 1, 0, 32'h20,       0, 0, 2'b10, 32'd6,        32'd2, 16'd3);
    vec("step_edge",     1, 32'h24,       2'd0, 1, 1, 1, 32'h20,       0, 0, 2'b10, 32'd6,        32'd2, 16'd3);
    vec("step_adv",      1, 32'h24,       2'd0, 1, 1, 1, 32'h20,       1, 1, 2'b11, 32'd6,        32'd2, 16'd3);
    vec("step_held1",    1, 32'h28,       2'd0, 1, 1, 1, 32'h24,       0, 0, 2'b10, 32'd7,        32'd2, 16'd3);
    vec("step_held2",    1, 32'h28,       2'd0, 1, 1, 1, 32'h24,       0, 0, 2'b10, 32'd7,        32'd2, 16'd3);
    vec("step_held3",    1, 32'h28,       2'd0, 1, 1, 1, 32'h24,       0, 0, 2'b10, 32'd7,        32'd2, 16'd3);
    vec("step_low",      1, 32'h28,       2'd0, 1, 1, 0, 32'h24,       0, 0, 2'b10, 32'd7,        32'd2, 16'd3);
    vec("step2_edge",    1, 32'h28,       2'd0, 0, 1, 1, 32'h24,       0, 0, 2'b10, 32'd7,        32'd2, 16'd3);
    vec("step2_stall1",  1, 32'h28,       2'd0, 0, 1, 0, 32'h24,       0, 1, 2'b11, 32'd7,        32'd2, 16'd3);
    vec("step2_stall2",  1, 32'h28,       2'd0, 0, 1, 0, 32'h24,       0, 1, 2'b11, 32'd7,        32'd2, 16'd4);
    vec("step2_adv",     1, 32'h28,       2'd0, 1, 1, 0, 32'h24,       1, 1, 2'b11, 32'd7,        32'd2, 16'd5);
    vec("halt_again",    1, 32'h2C,       2'd0, 1, 1, 0, 32'h28,       0, 0, 2'b10, 32'd8,        32'd2, 16'd5);
    vec("resume",        1, 32'h2C,       2'd0, 1, 0, 1, 32'h28,       0, 0, 2'b10, 32'd8,        32'd2, 16'd5);
    vec("resumed_adv",   1, 32'h2C,       2'd0, 1, 0, 0, 32'h28,       1, 1, 2'b01, 32'd8,        32'd2, 16'd5);
    vec("run_adv4",      1, 32'h30,       2'd0, 1, 0, 0, 32'h2C,       1, 1, 2'b01, 32'd9,        32'd2, 16'd5);
    vec("halt3",         1, 32'h34,       2'd0, 1, 1, 0, 32'h30,       0, 1, 2'b01, 32'd10,       32'd2, 16'd5);
    vec("step3_edge",    1, 32'h34,       2'd0, 0, 1, 1, 32'h30,       0, 0, 2'b10, 32'd10,       32'd2, 16'd5);
    vec("in_step",       1, 32'h34,       2'd0, 0, 1, 1, 32'h30,       0, 1, 2'b11, 32'd10,       32'd2, 16'd5);
    vec("async_rst",     0, 32'h34,       2'd0, 0, 1, 1, 32'h0,        0, 0, 2'b00, 32'd0,        32'd0, 16'd0);
    vec("boot_halt",     1, 32'h4,        2'd0, 1, 1, 0, 32'h0,        0, 0, 2'b00, 32'd0,        32'd0, 16'd0);
    vec("boot_to_halt",  1, 32'h4,        2'd0, 1, 1, 0, 32'h0,        0, 0, 2'b10, 32'd0,        32'd0, 16'd0);

    // preload counters near their limits while halted (counters hold)
    @(negedge clock);
    force dut.stall_cnt = 16'hFFFE;
    force dut.fetch_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    release dut.fetch_cnt;

    vec("sat_resume",    1, 32'h4,        2'd0, 0, 0, 0, 32'h0,        0, 0, 2'b10, 32'hFFFF_FFFF, 32'd0, 16'hFFFE);
    vec("sat1",          1, 32'h4,        2'd0, 0, 0, 0, 32'h0,        0, 1, 2'b01, 32'hFFFF_FFFF, 32'd0, 16'hFFFE);
    vec("sat2",          1, 32'h4,        2'd0, 0, 0, 0, 32'h0,        0, 1, 2'b01, 32'hFFFF_FFFF, 32'd0, 16'hFFFF);
    vec("sat3",          1, 32'h4,        2'd0, 0, 0, 0, 32'h0,        0, 1, 2'b01, 32'hFFFF_FFFF, 32'd0, 16'hFFFF);
    vec("wrap_adv",      1, 32'h4,        2'd0, 1, 0, 0, 32'h0,        1, 1, 2'b01, 32'hFFFF_FFFF, 32'd0, 16'hFFFF);
    vec("after_wrap",    1, 32'h8,        2'd0, 0, 0, 0, 32'h4,        0, 1, 2'b01, 32'd0,        32'd0, 16'hFFFF);

    @(negedge clock);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule
